// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the PC / instruction-fetch stage: next-PC mux selects and fetch FSM states.
package pc_fetch_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_BR  = 2'b01,
    SEL_J   = 2'b10,
    SEL_JR  = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    DRAIN = 2'b01,
    HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect targets: branch (PC+4 relative), jump (region + index) and jr (register).
module pc_target_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [DATA_W-1:0] redir_pc4,
  input  logic [15:0]       br_off,
  input  logic [25:0]       j_index,
  input  logic [DATA_W-1:0] jr_target,
  output logic [DATA_W-1:0] br_tgt,
  output logic [DATA_W-1:0] j_tgt,
  output logic [DATA_W-1:0] jr_tgt
);

  logic signed [DATA_W-1:0] br_disp;
  logic signed [DATA_W-1:0] br_sum;

  // Word offset: sign-extend the immediate and scale to bytes.
  assign br_disp = {{(DATA_W-18){br_off[15]}}, br_off, 2'b00};
  assign br_sum  = $signed(redir_pc4) + br_disp;
  assign br_tgt  = $unsigned(br_sum);

  assign j_tgt  = {redir_pc4[DATA_W-1:DATA_W-4], j_index, 2'b00};
  assign jr_tgt = jr_target;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, next-PC candidate/select generation, one-outstanding instruction fetch and
// wrong-path squashing with a saturating discard counter.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          SQ_CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  output logic [31:0]         cand0,
  output logic [31:0]         cand1,
  output logic [31:0]         cand2,
  output logic [31:0]         cand3,
  output logic                sel_s0,
  output logic                sel_s1,
  input  logic [31:0]         next_pc,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic [31:0]         instr_pc,
  output logic                instr_valid,
  input  logic                dec_ready,
  input  logic                br_taken,
  input  logic                j_en,
  input  logic                jr_en,
  input  logic [31:0]         redir_pc4,
  input  logic [15:0]         br_off,
  input  logic [25:0]         j_index,
  input  logic [31:0]         jr_target,
  output logic [SQ_CNT_W-1:0] squash_cnt
);

  state_e      state, state_nxt;
  logic [31:0] pc;

  logic        pend_vld;
  sel_e        pend_sel;
  logic [31:0] pend_tgt;

  logic [31:0] br_tgt, j_tgt, jr_tgt;
  logic        redir_new;
  sel_e        new_sel;
  logic [31:0] new_tgt;
  logic        redir_any;
  sel_e        eff_sel;

  logic        pc_load, capture, drop_valid, sq_inc, consume;

  function automatic logic [SQ_CNT_W-1:0] sat_inc(input logic [SQ_CNT_W-1:0] v);
    return (&v) ? v : v + SQ_CNT_W'(1);
  endfunction

  pc_target_calc u_tgt (
    .redir_pc4 (redir_pc4),
    .br_off    (br_off),
    .j_index   (j_index),
    .jr_target (jr_target),
    .br_tgt    (br_tgt),
    .j_tgt     (j_tgt),
    .jr_tgt    (jr_tgt)
  );

  // A pulse arriving this cycle wins over the pending entry so same-cycle redirects steer next_pc.
  always_comb begin
    redir_new = jr_en | j_en | br_taken;
    new_sel   = SEL_SEQ;
    new_tgt   = br_tgt;
    if (jr_en) begin
      new_sel = SEL_JR;
      new_tgt = jr_tgt;
    end else if (j_en) begin
      new_sel = SEL_J;
      new_tgt = j_tgt;
    end else if (br_taken) begin
      new_sel = SEL_BR;
      new_tgt = br_tgt;
    end
    redir_any = redir_new | pend_vld;
    eff_sel   = redir_new ? new_sel : (pend_vld ? pend_sel : SEL_SEQ);
  end

  assign cand0 = pc + 32'd4;
  assign cand1 = (pend_vld && !redir_new) ? pend_tgt : br_tgt;
  assign cand2 = (pend_vld && !redir_new) ? pend_tgt : j_tgt;
  assign cand3 = (pend_vld && !redir_new) ? pend_tgt : jr_tgt;

  assign {sel_s1, sel_s0} = reset ? SEL_SEQ : eff_sel;
  assign imem_req         = !reset && (state == FETCH);
  assign imem_addr        = pc;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_load    = 1'b0;
    capture    = 1'b0;
    drop_valid = 1'b0;
    sq_inc     = 1'b0;
    consume    = 1'b0;
    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          if (redir_any) begin
            sq_inc  = 1'b1;
            pc_load = 1'b1;
            consume = 1'b1;
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end else if (redir_new) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          sq_inc    = 1'b1;
          pc_load   = 1'b1;
          consume   = 1'b1;
          state_nxt = FETCH;
        end
      end
      HOLD: begin
        if (dec_ready) begin
          pc_load    = 1'b1;
          consume    = 1'b1;
          drop_valid = 1'b1;
          state_nxt  = FETCH;
        end else if (redir_new) begin
          sq_inc     = 1'b1;
          pc_load    = 1'b1;
          consume    = 1'b1;
          drop_valid = 1'b1;
          state_nxt  = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      squash_cnt  <= '0;
      pend_vld    <= 1'b0;
    end else begin
      if (pc_load) pc <= next_pc;
      if (capture) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (drop_valid) begin
        instr_valid <= 1'b0;
      end
      if (sq_inc) squash_cnt <= sat_inc(squash_cnt);
      if (consume)        pend_vld <= 1'b0;
      else if (redir_new) pend_vld <= 1'b1;
    end
  end

  // Pending redirect payload; only meaningful while pend_vld is set.
  always_ff @(posedge clk) begin
    if (redir_new && !consume) begin
      pend_sel <= new_sel;
      pend_tgt <= new_tgt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_fetch_unit;

  localparam int SQW    = 4;
  localparam int SQ_MAX = 15;

  logic        clk;
  logic        reset;
  logic [31:0] cand0, cand1, cand2, cand3;
  logic        sel_s0, sel_s1;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr, instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic        br_taken, j_en, jr_en;
  logic [31:0] redir_pc4;
  logic [15:0] br_off;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [SQW-1:0] squash_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  pc_fetch_unit #(.RESET_PC(32'h0), .SQ_CNT_W(SQW)) dut (
    .clk(clk), .reset(reset),
    .cand0(cand0), .cand1(cand1), .cand2(cand2), .cand3(cand3),
    .sel_s0(sel_s0), .sel_s1(sel_s1), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .dec_ready(dec_ready),
    .br_taken(br_taken), .j_en(j_en), .jr_en(jr_en),
    .redir_pc4(redir_pc4), .br_off(br_off), .j_index(j_index), .jr_target(jr_target),
    .squash_cnt(squash_cnt)
  );

  // External 4:1 next-PC mux.
  always_comb begin
    case ({sel_s1, sel_s0})
      2'b00:   next_pc = cand0;
      2'b01:   next_pc = cand1;
      2'b10:   next_pc = cand2;
      default: next_pc = cand3;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: one request at a time, configurable or random latency.
  int          mem_lat = 0;
  bit          mem_busy = 0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = 0;
  int          word_tag = 0;

  task automatic step(input bit rst, input bit dr, input bit br = 0, input bit j = 0, input bit jr = 0,
                      input logic [31:0] pc4 = 0, input logic [15:0] off = 0,
                      input logic [25:0] idx = 0, input logic [31:0] jrt = 0);
    @(posedge clk);
    #1;
    reset = rst; dec_ready = dr; br_taken = br; j_en = j; jr_en = jr;
    redir_pc4 = pc4; br_off = off; j_index = idx; jr_target = jrt;
    imem_ack = 1'b0;
    #1;
    if (rst) begin
      mem_busy   = 0;
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end else begin
      if (!mem_busy && imem_req) begin
        mem_busy = 1;
        mem_addr = imem_addr;
        mem_wait = (mem_lat < 0) ? int'($urandom_range(0, 2)) : mem_lat;
      end
      if (mem_busy) begin
        if (mem_wait == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = {mem_addr[15:0], 16'(word_tag)};
          word_tag++;
          mem_busy = 0;
        end else begin
          mem_wait--;
        end
      end
    end
  endtask

  // Behavioural model: mode 0 = waiting for a fetch, 1 = discarding an in-flight fetch, 2 = holding a word.
  bit          m_ok = 0;
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ipc, m_ptgt;
  bit          m_vld, m_pv;
  int          m_sq, m_psel;
  int          es, d;
  logic [31:0] et, npc, ec;
  bit          pulse;

  always @(negedge clk) begin
    pulse = jr_en | j_en | br_taken;
    es = 0;
    et = 0;
    if (jr_en) begin
      es = 3; et = jr_target;
    end else if (j_en) begin
      es = 2; et = (redir_pc4 & 32'hF000_0000) | (32'(j_index) << 2);
    end else if (br_taken) begin
      es = 1; d = int'($signed(br_off)); et = redir_pc4 + 32'(d * 4);
    end else if (m_pv) begin
      es = m_psel; et = m_ptgt;
    end
    if (reset) es = 0;
    if (m_ok) begin
      check("imem_req", 32'(imem_req), 32'(!reset && m_mode == 0));
      check("imem_addr", imem_addr, m_pc);
      check("cand0", cand0, m_pc + 32'd4);
      check("instr_valid", 32'(instr_valid), 32'(m_vld));
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_ipc);
      check("squash_cnt", 32'(squash_cnt), 32'(m_sq));
      check("sel", 32'({sel_s1, sel_s0}), 32'(es));
      if (es != 0) begin
        case (es)
          1:       ec = cand1;
          2:       ec = cand2;
          default: ec = cand3;
        endcase
        check("redirect_target", ec, et);
      end
    end
    npc = (es == 0) ? m_pc + 32'd4 : et;
    if (reset) begin
      m_ok = 1; m_mode = 0; m_pc = 32'h0; m_vld = 0; m_instr = 0; m_ipc = 0; m_sq = 0; m_pv = 0;
    end else if (m_ok) begin
      case (m_mode)
        0: begin
          if (imem_ack) begin
            if (es != 0) begin
              m_sq = (m_sq == SQ_MAX) ? SQ_MAX : m_sq + 1;
              m_pc = npc; m_pv = 0;
            end else begin
              m_instr = imem_rdata; m_ipc = m_pc; m_vld = 1; m_mode = 2;
            end
          end else if (pulse) begin
            m_pv = 1; m_psel = es; m_ptgt = et; m_mode = 1;
          end
        end
        1: begin
          if (imem_ack) begin
            m_sq = (m_sq == SQ_MAX) ? SQ_MAX : m_sq + 1;
            m_pc = npc; m_pv = 0; m_mode = 0;
          end else if (pulse) begin
            m_psel = es; m_ptgt = et;
          end
        end
        default: begin
          if (dec_ready) begin
            m_pc = npc; m_vld = 0; m_pv = 0; m_mode = 0;
          end else if (pulse) begin
            m_sq = (m_sq == SQ_MAX) ? SQ_MAX : m_sq + 1;
            m_pc = npc; m_vld = 0; m_mode = 0;
          end
        end
      endcase
    end
  end

  logic [31:0] addrs[$];
  logic [31:0] saved;
  bit          found;

  initial begin
    reset = 1; dec_ready = 1; br_taken = 0; j_en = 0; jr_en = 0;
    redir_pc4 = 0; br_off = 0; j_index = 0; jr_target = 0;
    imem_ack = 0; imem_rdata = 0;
    mem_lat = 0;
    step(1, 1);
    step(1, 1);

    // Sequential fetches from reset.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 1);
      #1;
      if (imem_req) begin
        addrs.push_back(imem_addr);
        if (addrs.size() == 1) check("seq_sel", 32'({sel_s1, sel_s0}), 32'h0);
        if (imem_addr == 32'h10) found = 1;
      end
    end
    check("seq_reach_0x10", 32'(found), 32'h1);
    if (addrs.size() >= 4) begin
      check("seq_addr0", addrs[0], 32'h0);
      check("seq_addr1", addrs[1], 32'h4);
      check("seq_addr2", addrs[2], 32'h8);
      check("seq_addr3", addrs[3], 32'hC);
    end else begin
      check("seq_addr_count", 32'(addrs.size()), 32'd4);
    end
    step(0, 0);
    #1;
    check("hold_pc10", instr_pc, 32'h10);

    // Branch taken while holding.
    step(0, 0, 1, 0, 0, 32'h14, 16'hFFFE);
    #1;
    check("br_sel", 32'({sel_s1, sel_s0}), 32'h1);
    check("br_cand1", cand1, 32'h0C);
    step(0, 0);
    #1;
    check("br_valid_drop", 32'(instr_valid), 32'h0);
    check("br_addr", imem_addr, 32'h0C);
    check("br_squash", 32'(squash_cnt), 32'h1);

    // Jump.
    step(0, 0);
    step(0, 0, 0, 1, 0, 32'h4000_0008, 16'h0, 26'h40);
    #1;
    check("j_cand2", cand2, 32'h4000_0100);
    check("j_sel", 32'({sel_s1, sel_s0}), 32'h2);
    step(0, 0);
    #1;
    check("j_addr", imem_addr, 32'h4000_0100);

    // jr beats branch in the same cycle.
    step(0, 0, 1, 0, 1, 32'h0, 16'h0, 26'h0, 32'h1234_5678);
    #1;
    check("jr_sel", 32'({sel_s1, sel_s0}), 32'h3);
    check("jr_next_pc", next_pc, 32'h1234_5678);

    // Redirect while a fetch is in flight.
    mem_lat = 2;
    step(0, 0);
    #1;
    check("jr_addr", imem_addr, 32'h1234_5678);
    step(0, 0, 1, 0, 0, 32'h100, 16'h0004);
    #1;
    check("drain_cand1", cand1, 32'h110);
    step(0, 0);
    #1;
    check("drain_req", 32'(imem_req), 32'h0);
    check("drain_sel", 32'({sel_s1, sel_s0}), 32'h1);
    check("drain_squash_before", 32'(squash_cnt), 32'h3);
    mem_lat = 0;
    step(0, 0);
    #1;
    check("drain_addr", imem_addr, 32'h110);
    check("drain_squash", 32'(squash_cnt), 32'h4);
    check("drain_no_word", 32'(instr_valid), 32'h0);
    step(0, 0);
    #1;
    check("drain_next_pc", instr_pc, 32'h110);

    // Stall, wrap, mid-hold reset.
    saved = instr;
    for (int i = 0; i < 5; i++) begin
      step(0, 0);
      #1;
      check("stall_instr", instr, saved);
    end
    step(0, 0, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
    step(0, 0);
    #1;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(0, 1);
    #1;
    check("wrap_cand0", cand0, 32'h0);
    step(0, 0);
    #1;
    check("wrap_addr0", imem_addr, 32'h0);
    step(0, 0);
    step(1, 0, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'h300);
    #1;
    check("rst_sel", 32'({sel_s1, sel_s0}), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    step(0, 0);
    #1;
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_squash", 32'(squash_cnt), 32'h0);

    // Drive the squash counter into saturation.
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'h200);
      step(0, 0);
    end
    #1;
    check("squash_sat", 32'(squash_cnt), 32'(SQ_MAX));

    // Randomized traffic.
    mem_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0), ($urandom_range(0, 13) == 0),
           $urandom, 16'($urandom), 26'($urandom), $urandom);
    end
    step(0, 1);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
